al4s3b_wb_regbank: RTL
======================

// Module: al4s3b_wb_regbank
// PURPOSE
//  Parametrised Wishbone register bank for the AL4S3B FPGA fabric; next-generation FPGA register block.
//  Provides ID/REV/scratch, N byte-writable control regs, M read-only status regs, a W1C event/IRQ block
//  and (optionally) a debug capture FIFO read through a pop-on-read register. Sits on the AHB-to-FPGA bridge.
// PARAMETERS
//  ADDRWIDTH        10            byte-address bits decoded (word index = WBs_ADR_i[ADDRWIDTH-1:2])
//  DATAWIDTH        32            bus width; fixed 32, byte strobes 4
//  NUM_CTRL         4             RW control regs, 1..16, at 0x040+4*i
//  NUM_STAT         4             RO status regs, 1..16, at 0x080+4*i
//  NUM_EVT          8             event inputs / IRQ bits, 1..31
//  DBG_DEPTH        16            debug FIFO depth, power of 2, 4..256
//  DEVICE_ID        32'h0         value at 0x000;  REV_LEVEL 32'h0 value at 0x004
//  SCRATCH_RST      32'h12345678  scratch reset value (0x008);  DEF_VALUE 32'hFABDEFAC unmapped read
// PORTS
//  WBs_CLK_i      in   1              bus/fabric clock, all logic on rising edge
//  WBs_RST_i      in   1              reset, asynchronous, active-low
//  WBs_ADR_i      in   17             byte address; WBs_CYC_i in 1 cycle; WBs_STB_i in 1 strobe
//  WBs_WE_i       in   1              write enable; WBs_BYTE_STB_i in 4 byte enables
//  WBs_DAT_i      in   32             write data;  WBs_DAT_o out 32 read data (registered)
//  WBs_ACK_o      out  1              transfer acknowledge
//  ctrl_o         out  32*NUM_CTRL    flattened control regs, reg i at [32*i+:32]
//  stat_i         in   32*NUM_STAT    flattened status inputs, synchronous to WBs_CLK_i
//  evt_i          in   NUM_EVT        level events, rising edge sets IRQ_STAT bit
//  irq_o          out  1              registered interrupt = |(IRQ_STAT & IRQ_EN)
//  dbg_push_i     in   1              debug FIFO push; dbg_data_i in 32 push data
//  Device_ID_o    out  32             constant DEVICE_ID
// BEHAVIOUR
//  - Access = CYC&STB&~ACK. ACK registered: high cycle after access, exactly 1 cycle; back-to-back gives
//    ACK every 2nd cycle. DAT_o loaded on the same edge ACK rises, held until next access.
//  - Writes: per-byte on BYTE_STB on the ACK-rising edge. Writes to ID/REV/STAT/unmapped ignored.
//  - Map: 0x000 ID, 0x004 REV, 0x008 SCRATCH, 0x00C IRQ_STAT (W1C), 0x010 IRQ_EN, 0x014 DBG_DATA,
//    0x018 DBG_LVL {ovf[31], 0, count[8:0]}; others read DEF_VALUE.
//  - Events: evt_i registered once; bit set on 0->1 of registered value. Same-cycle set and W1C: set wins.
//  - irq_o updated 1 cycle after IRQ_STAT/IRQ_EN change.
//  - Reset: ACK 0, DAT_o 0, ctrl_o 0, SCRATCH SCRATCH_RST, IRQ_STAT/EN 0, irq_o 0, FIFO empty, ovf 0,
//    event history 0 (evt_i high at reset release does not set a bit). Reset mid-transfer drops it, no ACK.
//  - DBG FIFO: push when not full; push while full is dropped, sets ovf (sticky; W1 bit31 of DBG_LVL clears).
//    Full with same-cycle pop: push accepted, count unchanged. Read DBG_DATA pops head on ACK-rising edge.
//    Read when empty returns 0, no pop. Count 0..DBG_DEPTH, never wraps.
// CONFIGURATION
//  AL4S3B_REGBANK_DBG_FIFO_EN defined: FIFO + 0x014/0x018 present.
//  Undefined: no FIFO storage; 0x014/0x018 read DEF_VALUE; dbg_push_i/dbg_data_i ignored.
// STRUCTURE
//  Package al4s3b_regbank_pkg: address offset localparams (ID/REV/SCRATCH/IRQ_STAT/IRQ_EN/DBG_DATA/DBG_LVL,
//  CTRL_BASE 0x040, STAT_BASE 0x080), DEF_VALUE, DBG_LVL bit positions.
//  Sub-module al4s3b_dbg_fifo (sync FIFO, count, full/empty, ovf) instantiated only under the macro.
// TESTING
//  1 Reset: drive WBs_RST_i=0 -> ctrl_o=0, irq_o=0, read 0x008 = 0x12345678, read 0x000 = DEVICE_ID.
//  2 Write 0x040 data 0xAABBCCDD BYTE_STB=4'b0101 -> ctrl_o[31:0]=0x00BB00DD; ACK exactly one cycle.
//  3 Pulse evt_i[3], IRQ_EN=0x08 -> IRQ_STAT=0x08, irq_o=1; write 0x00C 0x08 same cycle as evt_i[3] edge
//    -> bit stays 1; later W1C alone -> 0, irq_o=0 next cycle.
//  4 Macro on, DBG_DEPTH=4: push 5 words 1..5 -> DBG_LVL=0x80000004; reads 0x014 return 1,2,3,4 then 0.
//  5 Read 0x200 (unmapped) -> 0xFABDEFAC; write 0x000 -> ID unchanged; macro off: 0x014 reads 0xFABDEFAC.
//  6 Assert reset between access and ACK -> no ACK, state = reset values.

Source files
------------

// File: rtl/al4s3b_regbank_pkg.sv
// Shared constants for the AL4S3B Wishbone register bank.
// Register byte offsets, unmapped-read value, DBG_LVL field layout and a byte-strobe
// mask helper used by every byte-writable register.
package al4s3b_regbank_pkg;

    localparam int unsigned ID_OFFSET       = 32'h000;
    localparam int unsigned REV_OFFSET      = 32'h004;
    localparam int unsigned SCRATCH_OFFSET  = 32'h008;
    localparam int unsigned IRQ_STAT_OFFSET = 32'h00C;
    localparam int unsigned IRQ_EN_OFFSET   = 32'h010;
    localparam int unsigned DBG_DATA_OFFSET = 32'h014;
    localparam int unsigned DBG_LVL_OFFSET  = 32'h018;
    localparam int unsigned CTRL_BASE       = 32'h040;
    localparam int unsigned STAT_BASE       = 32'h080;

    localparam logic [31:0] DEF_VALUE = 32'hFABDEFAC;

    // DBG_LVL = {ovf[31], zeros, count[8:0]}
    localparam int unsigned DBG_LVL_OVF_BIT = 31;
    localparam int unsigned DBG_CNT_W       = 9;

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/al4s3b_dbg_fifo.sv
// Debug capture FIFO for the register bank.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data when space (or a same-cycle pop) allows
//   pop         : remove head; ignored when empty
//   ovf_clr     : clear sticky overflow flag
//   head        : current head word, 0 when empty
//   count       : occupancy 0..DEPTH (saturates, never wraps)
//   ovf         : sticky, set by a push that was dropped because the FIFO was full
module al4s3b_dbg_fifo
    import al4s3b_regbank_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [31:0]          push_data,
    input  logic                 pop,
    input  logic                 ovf_clr,
    output logic [31:0]          head,
    output logic [DBG_CNT_W-1:0] count,
    output logic                 ovf
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == DBG_CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + DBG_CNT_W'(do_push) - DBG_CNT_W'(do_pop);
            // Overflow set takes priority over a same-cycle clear.
            if (push && !do_push) ovf <= 1'b1;
            else if (ovf_clr)     ovf <= 1'b0;
        end
    end

    // Storage carries no reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/al4s3b_wb_regbank.sv
// Wishbone register bank for the AL4S3B FPGA fabric.
// Map: ID, REV, SCRATCH, IRQ_STAT (W1C), IRQ_EN, optional DBG_DATA/DBG_LVL,
// NUM_CTRL byte-writable control regs at 0x040, NUM_STAT read-only status regs at 0x080.
// Ports:
//   WBs_*         : Wishbone slave (registered single-cycle ACK, registered read data)
//   ctrl_o        : flattened control regs, reg i at [32*i +: 32]
//   stat_i        : flattened status inputs, reg i at [32*i +: 32]
//   evt_i / irq_o : level events (rising edge latches IRQ_STAT) / registered interrupt
//   dbg_push_i, dbg_data_i : debug FIFO push interface
//   Device_ID_o   : constant DEVICE_ID
// Build option: define AL4S3B_REGBANK_DBG_FIFO_EN to include the debug FIFO.
module al4s3b_wb_regbank
    import al4s3b_regbank_pkg::*;
#(
    parameter int unsigned ADDRWIDTH   = 10,
    parameter int unsigned DATAWIDTH   = 32,
    parameter int unsigned NUM_CTRL    = 4,
    parameter int unsigned NUM_STAT    = 4,
    parameter int unsigned NUM_EVT     = 8,
    parameter int unsigned DBG_DEPTH   = 16,
    parameter logic [31:0] DEVICE_ID   = 32'h0,
    parameter logic [31:0] REV_LEVEL   = 32'h0,
    parameter logic [31:0] SCRATCH_RST = 32'h12345678
) (
    input  logic                     WBs_CLK_i,
    input  logic                     WBs_RST_i,
    input  logic [16:0]              WBs_ADR_i,
    input  logic                     WBs_CYC_i,
    input  logic                     WBs_STB_i,
    input  logic                     WBs_WE_i,
    input  logic [3:0]               WBs_BYTE_STB_i,
    input  logic [DATAWIDTH-1:0]     WBs_DAT_i,
    output logic [DATAWIDTH-1:0]     WBs_DAT_o,
    output logic                     WBs_ACK_o,
    output logic [32*NUM_CTRL-1:0]   ctrl_o,
    input  logic [32*NUM_STAT-1:0]   stat_i,
    input  logic [NUM_EVT-1:0]       evt_i,
    output logic                     irq_o,
    input  logic                     dbg_push_i,
    input  logic [31:0]              dbg_data_i,
    output logic [31:0]              Device_ID_o
);

    logic [ADDRWIDTH-1:0]  off;
    logic                  access;
    logic                  wr;
    logic                  rd;
    logic [31:0]           bmask;
    logic [31:0]           rd_data;

    logic                  ack;
    logic [31:0]           dat;
    logic [31:0]           scratch;
    logic [32*NUM_CTRL-1:0] ctrl;
    logic [NUM_EVT-1:0]    irq_stat;
    logic [NUM_EVT-1:0]    irq_stat_next;
    logic [NUM_EVT-1:0]    irq_en;
    logic [NUM_EVT-1:0]    irq_clr;
    logic                  irq;
    logic [NUM_EVT-1:0]    evt_q;
    logic [NUM_EVT-1:0]    evt_qq;
    logic [NUM_EVT-1:0]    evt_rise;
    logic                  evt_primed;

    logic unused_adr;
    assign unused_adr = ^{WBs_ADR_i[16:ADDRWIDTH], WBs_ADR_i[1:0]};

    assign off    = {WBs_ADR_i[ADDRWIDTH-1:2], 2'b00};
    assign access = WBs_CYC_i & WBs_STB_i & ~ack;
    assign wr     = access & WBs_WE_i;
    assign rd     = access & ~WBs_WE_i;
    assign bmask  = byte_mask(WBs_BYTE_STB_i);

`ifdef AL4S3B_REGBANK_DBG_FIFO_EN
    logic [31:0]          fifo_head;
    logic [DBG_CNT_W-1:0] fifo_count;
    logic                 fifo_ovf;
    logic                 fifo_pop;
    logic                 fifo_ovf_clr;

    assign fifo_pop     = rd & (off == ADDRWIDTH'(DBG_DATA_OFFSET));
    assign fifo_ovf_clr = wr & (off == ADDRWIDTH'(DBG_LVL_OFFSET)) & WBs_BYTE_STB_i[3]
                          & WBs_DAT_i[DBG_LVL_OVF_BIT];

    al4s3b_dbg_fifo #(
        .DEPTH (DBG_DEPTH)
    ) u_dbg_fifo (
        .clk       (WBs_CLK_i),
        .rst_n     (WBs_RST_i),
        .push      (dbg_push_i),
        .push_data (dbg_data_i),
        .pop       (fifo_pop),
        .ovf_clr   (fifo_ovf_clr),
        .head      (fifo_head),
        .count     (fifo_count),
        .ovf       (fifo_ovf)
    );
`else
    localparam int unsigned unused_dbg_depth = DBG_DEPTH;
    logic unused_dbg;
    assign unused_dbg = ^{dbg_push_i, dbg_data_i};
`endif

    // Read mux; anything not decoded returns DEF_VALUE.
    always_comb begin
        rd_data = DEF_VALUE;
        if (off == ADDRWIDTH'(ID_OFFSET)) begin
            rd_data = DEVICE_ID;
        end else if (off == ADDRWIDTH'(REV_OFFSET)) begin
            rd_data = REV_LEVEL;
        end else if (off == ADDRWIDTH'(SCRATCH_OFFSET)) begin
            rd_data = scratch;
        end else if (off == ADDRWIDTH'(IRQ_STAT_OFFSET)) begin
            rd_data = 32'(irq_stat);
        end else if (off == ADDRWIDTH'(IRQ_EN_OFFSET)) begin
            rd_data = 32'(irq_en);
`ifdef AL4S3B_REGBANK_DBG_FIFO_EN
        end else if (off == ADDRWIDTH'(DBG_DATA_OFFSET)) begin
            rd_data = fifo_head;
        end else if (off == ADDRWIDTH'(DBG_LVL_OFFSET)) begin
            rd_data = '0;
            rd_data[DBG_LVL_OVF_BIT]  = fifo_ovf;
            rd_data[DBG_CNT_W-1:0]    = fifo_count;
`endif
        end
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (off == ADDRWIDTH'(CTRL_BASE + 4 * i)) rd_data = ctrl[32*i +: 32];
        end
        for (int i = 0; i < NUM_STAT; i++) begin
            if (off == ADDRWIDTH'(STAT_BASE + 4 * i)) rd_data = stat_i[32*i +: 32];
        end
    end

    // Event set wins over a same-cycle W1C of the same bit.
    always_comb begin
        evt_rise = evt_q & ~evt_qq;
        irq_clr  = '0;
        if (wr && off == ADDRWIDTH'(IRQ_STAT_OFFSET)) begin
            irq_clr = WBs_DAT_i[NUM_EVT-1:0] & bmask[NUM_EVT-1:0];
        end
        irq_stat_next = (irq_stat & ~irq_clr) | evt_rise;
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
        if (!WBs_RST_i) begin
            ack        <= 1'b0;
            dat        <= '0;
            scratch    <= SCRATCH_RST;
            ctrl       <= '0;
            irq_stat   <= '0;
            irq_en     <= '0;
            irq        <= 1'b0;
            evt_q      <= '0;
            evt_qq     <= '0;
            evt_primed <= 1'b0;
        end else begin
            ack <= access;
            if (access) dat <= rd_data;
            if (wr) begin
                if (off == ADDRWIDTH'(SCRATCH_OFFSET)) begin
                    scratch <= (scratch & ~bmask) | (WBs_DAT_i & bmask);
                end
                if (off == ADDRWIDTH'(IRQ_EN_OFFSET)) begin
                    irq_en <= (irq_en & ~bmask[NUM_EVT-1:0])
                              | (WBs_DAT_i[NUM_EVT-1:0] & bmask[NUM_EVT-1:0]);
                end
                for (int i = 0; i < NUM_CTRL; i++) begin
                    if (off == ADDRWIDTH'(CTRL_BASE + 4 * i)) begin
                        ctrl[32*i +: 32] <= (ctrl[32*i +: 32] & ~bmask) | (WBs_DAT_i & bmask);
                    end
                end
            end
            irq_stat <= irq_stat_next;
            irq      <= |(irq_stat & irq_en);
            // First sample after reset seeds both history stages, so a level that is
            // already high at reset release is not seen as an edge.
            evt_primed <= 1'b1;
            evt_q      <= evt_i;
            evt_qq     <= evt_primed ? evt_q : evt_i;
        end
    end

    assign WBs_ACK_o   = ack;
    assign WBs_DAT_o   = dat;
    assign ctrl_o      = ctrl;
    assign irq_o       = irq;
    assign Device_ID_o = DEVICE_ID;

endmodule
